// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset vector and FSM encoding for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned INS_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] RST_PC_DEFAULT = 32'h8000_0000;
  localparam logic [CPU_WIDTH-1:0] PC_STEP        = 32'd4;

  typedef enum logic [1:0] {
    StReq  = 2'b00,
    StWait = 2'b01,
    StHold = 2'b10
  } fetch_state_e;

  function automatic logic [CPU_WIDTH-1:0] align_word(input logic [CPU_WIDTH-1:0] addr);
    return {addr[CPU_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: request, wait for response, hold for decoder.
// Redirects retarget the pc; a response already in flight is drained and discarded.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RST_PC = RST_PC_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_imem_req,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INS_WIDTH-1:0] i_imem_rdata,
  output logic [INS_WIDTH-1:0] o_instr,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc
);

  fetch_state_e         r_state;
  fetch_state_e         w_state_nxt;
  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] w_pc_nxt;
  logic                 r_kill;
  logic                 w_kill_nxt;
  logic                 w_capture;
  logic [INS_WIDTH-1:0] r_instr;
  logic [CPU_WIDTH-1:0] r_pc_out;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StReq;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a response is routed back to REQ when it belongs to a dead path
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StReq: begin
        if (i_imem_gnt) w_state_nxt = StWait;
      end
      StWait: begin
        if (i_imem_rvalid) w_state_nxt = (r_kill || i_redirect) ? StReq : StHold;
      end
      StHold: begin
        if (i_redirect || i_post_ready) w_state_nxt = StReq;
      end
      default: w_state_nxt = StReq;
    endcase
  end

  // Outputs
  always_comb begin
    o_imem_req   = (r_state == StReq);
    o_imem_addr  = r_pc;
    o_post_valid = (r_state == StHold) && !i_redirect;
    o_instr      = r_instr;
    o_pc         = r_pc_out;
  end

  // Datapath next-state: pc, kill flag and capture strobe
  always_comb begin
    w_pc_nxt   = r_pc;
    w_kill_nxt = r_kill;
    w_capture  = 1'b0;
    unique case (r_state)
      StReq: begin
        if (i_redirect) begin
          w_pc_nxt = align_word(i_redirect_pc);
          // The granted request fetches the old pc, so its response must be dropped
          if (i_imem_gnt) w_kill_nxt = 1'b1;
        end
      end
      StWait: begin
        if (i_imem_rvalid) begin
          w_kill_nxt = 1'b0;
          w_capture  = !r_kill && !i_redirect;
        end
        if (i_redirect) begin
          w_pc_nxt = align_word(i_redirect_pc);
          if (!i_imem_rvalid) w_kill_nxt = 1'b1;
        end
      end
      StHold: begin
        if (i_redirect) begin
          w_pc_nxt = align_word(i_redirect_pc);
        end else if (i_post_ready) begin
          w_pc_nxt = r_pc + PC_STEP;
        end
      end
      default: begin
        w_pc_nxt   = r_pc;
        w_kill_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc     <= RST_PC;
      r_kill   <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_kill <= w_kill_nxt;
      if (w_capture) begin
        r_instr  <= i_imem_rdata;
        r_pc_out <= r_pc;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
      $display("ifu_fetch: warning: misaligned redirect target %h, using %h",
               i_redirect_pc, align_word(i_redirect_pc));
    end
  end
`endif

endmodule
